// File: rtl/feistel_stream_ctrl_pkg.sv
// Shared definitions for the Feistel stream controller: default geometry,
// FSM state encoding and the output FIFO entry layout.
package feistel_stream_ctrl_pkg;

  localparam int FSC_DATA_WIDTH  = 256;
  localparam int FSC_WORD_WIDTH  = 32;
  localparam int FSC_OFIFO_DEPTH = 8;
  localparam int WORDS           = FSC_DATA_WIDTH / FSC_WORD_WIDTH;

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2
  } fsc_state_e;

  // One buffered ciphertext block plus its end-of-frame flag.
  typedef struct packed {
    logic [FSC_DATA_WIDTH-1:0] ciphertext;
    logic                      last;
  } ofifo_entry_t;

endpackage

// File: rtl/feistel_ofifo.sv
// Synchronous FIFO with occupancy output. DEPTH must be a power of two so
// the pointers wrap naturally. A write is accepted while full when a read
// happens in the same cycle.
module feistel_ofifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q];

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_wr) - CW'(do_rd);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/feistel_stream_ctrl.sv
// Stream-side controller for the pipelined Feistel core: packs words into
// blocks, issues blocks only when output space is guaranteed by credits,
// buffers returned ciphertext and unpacks it back to a word stream.
// Optional statistics outputs are enabled by FEISTEL_CTRL_STATS_EN.
// The package entry type tracks the default DATA_WIDTH.
module feistel_stream_ctrl
  import feistel_stream_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = FSC_DATA_WIDTH,
  parameter int WORD_WIDTH  = FSC_WORD_WIDTH,
  parameter int OFIFO_DEPTH = FSC_OFIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  key_valid,
  input  logic                  sbox_ready,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [WORD_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  output logic                  enc_tvalid,
  output logic [DATA_WIDTH-1:0] enc_plaintext,
  input  logic                  enc_valid,
  input  logic [DATA_WIDTH-1:0] enc_ciphertext,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [WORD_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  err_overflow
`ifdef FEISTEL_CTRL_STATS_EN
  ,
  output logic [31:0]           blk_issued_cnt,
  output logic [15:0]           frame_cnt
`endif
);

  localparam int N_WORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int CNT_W   = $clog2(OFIFO_DEPTH) + 1;
  localparam int SUM_W   = CNT_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  fsc_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] blk_q, blk_d;
  logic [IDX_W-1:0]      widx_q, widx_d;
  logic                  blk_full_q, blk_full_d;
  logic                  blk_last_q, blk_last_d;
  logic [IDX_W-1:0]      ridx_q, ridx_d;
  logic                  err_q, err_d;

  logic                  accept, issue, credit_ok, ret_ok, out_hs, ofifo_pop;
  logic                  ofifo_full, ofifo_empty;
  logic [CNT_W-1:0]      ofifo_count;
  ofifo_entry_t          ofifo_wr, ofifo_head;
  logic                  tag_head, tag_full, tag_empty;
  logic [CNT_W-1:0]      inflight;
  logic [WORD_WIDTH-1:0] head_words [N_WORDS];

  // Handshakes and credit. A block may only be issued if its ciphertext
  // is guaranteed a FIFO slot, since the core cannot be stalled.
  assign s_tready  = (state_q == RUN) && !blk_full_q;
  assign accept    = s_tvalid && s_tready;
  assign credit_ok = (SUM_W'(ofifo_count) + SUM_W'(inflight)) < SUM_W'(OFIFO_DEPTH);
  assign issue     = blk_full_q && key_valid && credit_ok && !tag_full;
  assign out_hs    = m_tvalid && m_tready;
  assign ofifo_pop = out_hs && (ridx_q == LAST_IDX);
  assign ret_ok    = enc_valid && (inflight != '0) && !tag_empty &&
                     (!ofifo_full || ofifo_pop);

  assign enc_tvalid    = issue;
  assign enc_plaintext = blk_q;
  assign busy          = (state_q != WAIT_CFG);
  assign err_overflow  = err_q;

  assign ofifo_wr.ciphertext = enc_ciphertext;
  assign ofifo_wr.last       = tag_head;

  // Ciphertext buffer; its depth bounds blocks in flight plus buffered.
  feistel_ofifo #(
    .WIDTH($bits(ofifo_entry_t)),
    .DEPTH(OFIFO_DEPTH)
  ) u_ofifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (ret_ok),
    .wr_data (ofifo_wr),
    .rd_en   (ofifo_pop),
    .rd_data (ofifo_head),
    .full    (ofifo_full),
    .empty   (ofifo_empty),
    .count   (ofifo_count)
  );

  // Tag queue carries each block's last flag across the core latency.
  // Its occupancy is exactly the number of blocks inside the core.
  feistel_ofifo #(
    .WIDTH(1),
    .DEPTH(OFIFO_DEPTH)
  ) u_tagq (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (issue),
    .wr_data (blk_last_q),
    .rd_en   (ret_ok),
    .rd_data (tag_head),
    .full    (tag_full),
    .empty   (tag_empty),
    .count   (inflight)
  );

  // Split the FIFO head into words, word 0 in the MSBs.
  for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_unpack
    assign head_words[gi] = ofifo_head.ciphertext[DATA_WIDTH-1-gi*WORD_WIDTH -: WORD_WIDTH];
  end

  // Output word is zeroed while nothing is valid so stale RAM never shows.
  assign m_tvalid = !ofifo_empty;
  assign m_tdata  = m_tvalid ? head_words[ridx_q] : '0;
  assign m_tlast  = m_tvalid && ofifo_head.last && (ridx_q == LAST_IDX);

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_CFG: if (key_valid && sbox_ready) state_d = RUN;
      RUN:      if (issue && blk_last_q) state_d = DRAIN;
      DRAIN:    if ((inflight == '0) && ofifo_empty && (ridx_q == '0)) state_d = WAIT_CFG;
      default:  state_d = WAIT_CFG;
    endcase
  end

  // Packing, issue bookkeeping, unpack index and sticky error.
  always_comb begin
    blk_d      = blk_q;
    widx_d     = widx_q;
    blk_full_d = blk_full_q;
    blk_last_d = blk_last_q;
    ridx_d     = ridx_q;
    err_d      = err_q | (enc_valid && !ret_ok);

    // Clearing on issue makes short blocks zero-padded for free.
    if (issue) begin
      blk_d      = '0;
      widx_d     = '0;
      blk_full_d = 1'b0;
      blk_last_d = 1'b0;
    end

    if (accept) begin
      for (int k = 0; k < N_WORDS; k++) begin
        if (widx_q == IDX_W'(k)) blk_d[DATA_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH] = s_tdata;
      end
      widx_d = widx_q + 1'b1;
      if ((widx_q == LAST_IDX) || s_tlast) begin
        blk_full_d = 1'b1;
        blk_last_d = s_tlast;
      end
    end

    if (out_hs) ridx_d = (ridx_q == LAST_IDX) ? '0 : ridx_q + 1'b1;
  end

  // Controller registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT_CFG;
      blk_q      <= '0;
      widx_q     <= '0;
      blk_full_q <= 1'b0;
      blk_last_q <= 1'b0;
      ridx_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      widx_q     <= widx_d;
      blk_full_q <= blk_full_d;
      blk_last_q <= blk_last_d;
      ridx_q     <= ridx_d;
      err_q      <= err_d;
    end
  end

`ifdef FEISTEL_CTRL_STATS_EN
  logic [31:0] blk_issued_cnt_q, blk_issued_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Free-running wrap-around statistics.
  always_comb begin
    blk_issued_cnt_d = blk_issued_cnt_q + (issue ? 32'd1 : 32'd0);
    frame_cnt_d      = frame_cnt_q + ((out_hs && m_tlast) ? 16'd1 : 16'd0);
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_issued_cnt_q <= '0;
      frame_cnt_q      <= '0;
    end else begin
      blk_issued_cnt_q <= blk_issued_cnt_d;
      frame_cnt_q      <= frame_cnt_d;
    end
  end

  assign blk_issued_cnt = blk_issued_cnt_q;
  assign frame_cnt      = frame_cnt_q;
`endif

endmodule
